// File: rtl/i2s_pkg.sv
// Shared I2S constants and types, used by both the receiver and the transmitter.
package i2s_pkg;

  localparam int unsigned FRAME_SLOTS      = 64;
  localparam int unsigned HALF_SLOTS       = 32;
  localparam int unsigned SAMPLE_W_DEFAULT = 24;

  typedef struct packed {
    logic [SAMPLE_W_DEFAULT-1:0] left;
    logic [SAMPLE_W_DEFAULT-1:0] right;
  } stereo_pair_t;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S master timing: bit-clock divider, 64-slot frame counter, word select and
// single-cycle strobes marking the clk cycles on which sck rises or falls.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       sck,
  output logic       ws,
  output logic [5:0] slot,
  output logic       rise,
  output logic       fall
);

  logic [7:0] div_q, div_d;
  logic       sck_q, sck_d;
  logic       ws_q, ws_d;
  logic [5:0] slot_q, slot_d;
  logic       tc;

  always_comb begin
    tc     = (div_q == 8'(CLK_DIV - 1));
    rise   = en && tc && !sck_q;
    fall   = en && tc && sck_q;
    div_d  = div_q;
    sck_d  = sck_q;
    ws_d   = ws_q;
    slot_d = slot_q;
    if (!en) begin
      div_d  = '0;
      sck_d  = 1'b0;
      ws_d   = 1'b0;
      slot_d = '0;
    end else begin
      div_d = tc ? '0 : div_q + 8'd1;
      if (tc) sck_d = ~sck_q;
      // ws follows the slot it is entering so it only moves with the falling edge
      if (fall) begin
        slot_d = slot_q + 6'd1;
        ws_d   = (slot_d >= 6'(HALF_SLOTS));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      sck_q  <= 1'b0;
      ws_q   <= 1'b0;
      slot_q <= '0;
    end else begin
      div_q  <= div_d;
      sck_q  <= sck_d;
      ws_q   <= ws_d;
      slot_q <= slot_d;
    end
  end

  assign sck  = sck_q;
  assign ws   = ws_q;
  assign slot = slot_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S microphone receiver: captures left/right words from sd and presents them
// as a stereo pair with a valid/ready handshake and a sticky overflow flag.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                sck,
  output logic                ws,
  input  logic                sd,
  output logic [SAMPLE_W-1:0] left,
  output logic [SAMPLE_W-1:0] right,
  output logic                valid,
  input  logic                ready,
  output logic                overflow
);

  logic [5:0]          slot;
  logic                rise, fall;
  logic [1:0]          sync_q;
  logic                sd_s;
  logic [31:0]         slot_w;
  logic                cap_left, cap_right, complete, frame_start;
  logic [SAMPLE_W-1:0] left_sr_q, right_sr_q;
  logic [SAMPLE_W-1:0] left_q, right_q;
  logic                done_q, valid_q, ovf_q;

  i2s_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .sck  (sck),
    .ws   (ws),
    .slot (slot),
    .rise (rise),
    .fall (fall)
  );

  // Slot 0 and slot 32 carry the one-bit I2S delay; data starts one slot later.
  always_comb begin
    slot_w      = {26'd0, slot};
    sd_s        = sync_q[1];
    cap_left    = rise && (slot_w >= 32'd1) && (slot_w <= SAMPLE_W);
    cap_right   = rise && (slot_w >= HALF_SLOTS + 32'd1) && (slot_w <= HALF_SLOTS + SAMPLE_W);
    complete    = rise && (slot_w == HALF_SLOTS + SAMPLE_W);
    frame_start = fall && (slot_w == FRAME_SLOTS - 32'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], sd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_sr_q  <= '0;
      right_sr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= complete;
      if (!en || frame_start) begin
        left_sr_q  <= '0;
        right_sr_q <= '0;
      end else begin
        if (cap_left)  left_sr_q  <= {left_sr_q[SAMPLE_W-2:0], sd_s};
        if (cap_right) right_sr_q <= {right_sr_q[SAMPLE_W-2:0], sd_s};
      end
    end
  end

  // A finished pair wins over an accept on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (done_q) begin
      if (!valid_q || ready) begin
        left_q  <= left_sr_q;
        right_q <= right_sr_q;
        valid_q <= 1'b1;
      end else begin
        ovf_q <= 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

  assign left     = left_q;
  assign right    = right_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: a microphone model driving framed data, a handshake
// reference model, table-driven handshake phases and enable/reset sequences.
module tb_i2s_rx;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned SW        = 24;
  localparam int unsigned FRAME_CLK = 2 * CLK_DIV * 64;
  localparam int          LAST      = 32 + SW;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          en    = 1'b0;
  logic          sd    = 1'b0;
  logic          ready = 1'b1;
  logic          sck, ws, valid, overflow;
  logic [SW-1:0] left, right;

  i2s_rx #(
    .CLK_DIV (CLK_DIV),
    .SAMPLE_W(SW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sck     (sck),
    .ws      (ws),
    .sd      (sd),
    .left    (left),
    .right   (right),
    .valid   (valid),
    .ready   (ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Microphone / frame model
  logic [SW-1:0] cur_l, cur_r, pend_l, pend_r;
  int            tb_slot  = 0;
  int            frame_no = 0;
  bit            fresh    = 0;

  task automatic new_frame();
    if (frame_no == 0) begin
      cur_l = 24'h800001;
      cur_r = 24'h7FFFFE;
    end else begin
      cur_l = SW'($urandom);
      cur_r = SW'($urandom);
    end
    frame_no++;
    fresh = 1;
  endtask

  function automatic logic slot_bit(input int s);
    if (s >= 1 && s <= int'(SW)) return cur_l[int'(SW) - s];
    if (s >= 33 && s <= LAST) return cur_r[LAST - s];
    return 1'($urandom_range(0, 1));
  endfunction

  // Handshake reference model and timing monitor
  logic          m_valid = 1'b0, m_ovf = 1'b0;
  logic [SW-1:0] m_left = '0, m_right = '0;
  logic          prev_sck = 1'b0, prev_ws = 1'b0, en_prev = 1'b0, rst_prev = 1'b0;
  int            cyc = 0, last_rise = 0, last_ws_rise = 0, xfers = 0;
  bit            timing_ok = 0, ws_ok = 0;

  always @(negedge clk) begin
    logic done;
    cyc++;
    done = 1'b0;
    if (!rst_n) begin
      m_valid = 1'b0; m_ovf = 1'b0; m_left = '0; m_right = '0;
    end
    check("state{valid,ovf,left,right}", {14'd0, valid, overflow, left, right},
          {14'd0, m_valid, m_ovf, m_left, m_right});
    if (rst_n && valid && ready) xfers++;
    if (!rst_n || !en) begin
      tb_slot = 0;
      if (!fresh) new_frame();
      sd = 1'($urandom_range(0, 1));
      timing_ok = 0;
      ws_ok = 0;
    end else begin
      if (sck && !prev_sck) begin
        if (tb_slot == LAST) begin
          done = 1'b1; pend_l = cur_l; pend_r = cur_r;
        end
        if (timing_ok) check("sck_period", 64'(cyc - last_rise), 64'(2 * CLK_DIV));
        last_rise = cyc;
        timing_ok = 1;
      end
      if (!sck && prev_sck) begin
        tb_slot = (tb_slot + 1) % 64;
        if (tb_slot == 0) new_frame();
        else fresh = 0;
        sd = slot_bit(tb_slot);
      end
      if (en_prev && rst_prev) check("ws_vs_slot", 64'(ws), 64'(tb_slot >= 32));
      if (ws && !prev_ws) begin
        if (ws_ok) check("frame_len", 64'(cyc - last_ws_rise), 64'(FRAME_CLK));
        last_ws_rise = cyc;
        ws_ok = 1;
      end
      if (!ws && prev_ws && ws_ok) check("ws_high", 64'(cyc - last_ws_rise), 64'(FRAME_CLK / 2));
    end
    if (rst_n) begin
      if (done) begin
        if (!m_valid || ready) begin
          m_left = pend_l; m_right = pend_r; m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
    end
    prev_sck = sck; prev_ws = ws; en_prev = en; rst_prev = rst_n;
  end

  // Bounded waits
  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected event", name);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 2 * int'(FRAME_CLK); i++) begin
      @(negedge clk);
      if (valid) return;
    end
    timeout("wait_valid");
  endtask

  task automatic wait_slot(input int s);
    for (int i = 0; i < 2 * int'(FRAME_CLK); i++) begin
      @(posedge clk); #1;
      if (tb_slot == s) return;
    end
    timeout("wait_slot");
  endtask

  // Returns just after the rise edge that completes a pair; the next edge loads it.
  task automatic wait_completion(output logic [SW-1:0] el, output logic [SW-1:0] er);
    logic ps;
    ps = sck;
    for (int i = 0; i < 3 * int'(FRAME_CLK); i++) begin
      @(posedge clk); #1;
      if (sck && !ps && tb_slot == LAST) begin
        el = cur_l; er = cur_r;
        return;
      end
      ps = sck;
    end
    el = '0; er = '0;
    timeout("wait_completion");
  endtask

  typedef struct {
    logic        rdy;
    int unsigned frames;
    int unsigned exp_xfers;
    logic        exp_ovf;
  } phase_t;

  phase_t        tbl[3];
  logic [SW-1:0] el1, er1, el2, er2;
  int            x0;

  initial begin
    tbl[0] = '{1'b1, 2, 2, 1'b0};
    tbl[1] = '{1'b0, 3, 0, 1'b1};
    tbl[2] = '{1'b1, 2, 3, 1'b1};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {12'd0, sck, ws, valid, overflow, left, right}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    en = 1'b1;

    // First pair after enable carries the fixed pattern
    wait_valid();
    check("first_left", 64'(left), 64'(24'h800001));
    check("first_right", 64'(right), 64'(24'h7FFFFE));

    // Hold a pair, then accept exactly on the load cycle of the next one
    @(posedge clk); #1;
    ready = 1'b0;
    wait_completion(el1, er1);
    wait_completion(el2, er2);
    check("hold_valid", 64'(valid), 64'd1);
    check("hold_pair", {16'd0, left, right}, {16'd0, el1, er1});
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    check("sameload_valid", 64'(valid), 64'd1);
    check("sameload_pair", {16'd0, left, right}, {16'd0, el2, er2});
    check("sameload_ovf", 64'(overflow), 64'd0);
    ready = 1'b1;

    // Disable mid-left-word, restore after 100 clk
    wait_slot(20);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("dis_sck_ws", {62'd0, sck, ws}, 64'd0);
    repeat (98) @(posedge clk);
    #1;
    check("dis_sck_ws_end", {62'd0, sck, ws}, 64'd0);
    en = 1'b1;
    wait_completion(el1, er1);
    @(posedge clk); #1;
    check("reen_valid", 64'(valid), 64'd1);
    check("reen_pair", {16'd0, left, right}, {16'd0, el1, er1});
    repeat (10) @(posedge clk);
    #1;

    // Handshake phases
    for (int p = 0; p < 3; p++) begin
      ready = tbl[p].rdy;
      x0 = xfers;
      repeat (tbl[p].frames * FRAME_CLK) @(posedge clk);
      #1;
      check($sformatf("phase%0d_xfers", p), 64'(xfers - x0), 64'(tbl[p].exp_xfers));
      check($sformatf("phase%0d_ovf", p), 64'(overflow), 64'(tbl[p].exp_ovf));
    end

    // Reset pulse in the middle of the right word
    wait_slot(40);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {12'd0, sck, ws, valid, overflow, left, right}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_completion(el1, er1);
    @(posedge clk); #1;
    check("postreset_valid", 64'(valid), 64'd1);
    check("postreset_pair", {16'd0, left, right}, {16'd0, el1, er1});
    check("postreset_ovf", 64'(overflow), 64'd0);
    repeat (FRAME_CLK) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
